// File: rtl/dmem_responder.sv
// Slow data-memory responder: LATENCY wait states with mem_stall back-pressure.
// Optional DMEM_STATS_EN adds read/write/stall activity counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        mem_stall,
    output logic        addr_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count
`endif
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic              req;
    logic              fault;
    logic [ADDR_W-1:0] idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic              rd_done;
    logic              wr_done;
    logic              unused_addr;

    assign req         = MemRead | MemWrite;
    assign fault       = (addr[1:0] != 2'b00) | (MemRead & MemWrite);
    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];

    // Array is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign mem_stall = 1'b0;
            assign rd        = (MemRead && !fault) ? mem_q[idx] : '0;
            assign addr_err  = req & fault;
            assign wr_en     = MemWrite & ~fault & ~rst;
            assign wr_idx    = idx;
            assign wr_data   = wd;
            assign rd_done   = MemRead & ~fault & ~rst;
            assign wr_done   = wr_en;
        end else begin : g_fsm
            typedef enum logic [1:0] {
                S_IDLE,
                S_WAIT,
                S_DONE
            } state_t;

            localparam logic [3:0] CNT_INIT =
                (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

            state_t            state_q, state_d;
            logic [3:0]        cnt_q, cnt_d;
            logic              op_wr_q, op_wr_d;
            logic              fault_q, fault_d;
            logic [ADDR_W-1:0] idx_q, idx_d;
            logic [31:0]       wd_q, wd_d;
            logic [31:0]       rd_q, rd_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    op_wr_q <= 1'b0;
                    fault_q <= 1'b0;
                    idx_q   <= '0;
                    wd_q    <= '0;
                    rd_q    <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    op_wr_q <= op_wr_d;
                    fault_q <= fault_d;
                    idx_q   <= idx_d;
                    wd_q    <= wd_d;
                    rd_q    <= rd_d;
                end
            end

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                op_wr_d   = op_wr_q;
                fault_d   = fault_q;
                idx_d     = idx_q;
                wd_d      = wd_q;
                rd_d      = rd_q;
                mem_stall = 1'b0;
                rd        = '0;
                addr_err  = 1'b0;
                wr_en     = 1'b0;
                rd_done   = 1'b0;
                wr_done   = 1'b0;
                unique case (state_q)
                    S_IDLE: begin
                        if (req) begin
                            mem_stall = 1'b1;
                            op_wr_d   = MemWrite;
                            fault_d   = fault;
                            idx_d     = idx;
                            wd_d      = wd;
                            rd_d      = '0;
                            cnt_d     = CNT_INIT;
                            if (LATENCY == 1) begin
                                state_d = S_DONE;
                                if (!MemWrite && !fault) begin
                                    rd_d = mem_q[idx];
                                end
                            end else begin
                                state_d = S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        mem_stall = 1'b1;
                        if (!req) begin
                            state_d = S_IDLE;
                        end else if (cnt_q == 4'd0) begin
                            state_d = S_DONE;
                            if (!op_wr_q && !fault_q) begin
                                rd_d = mem_q[idx_q];
                            end
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    S_DONE: begin
                        rd       = rd_q;
                        addr_err = fault_q;
                        rd_d     = '0;
                        state_d  = S_IDLE;
                        // Write lands on the edge leaving DONE, before the next sample.
                        if (!fault_q && !rst) begin
                            wr_en   = op_wr_q;
                            wr_done = op_wr_q;
                            rd_done = ~op_wr_q;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end

            assign wr_idx  = idx_q;
            assign wr_data = wd_q;
        end
    endgenerate

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q    <= '0;
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (rd_done) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_done) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (mem_stall) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_stats;
    assign unused_stats = rd_done ^ wr_done;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder (LATENCY=2 and LATENCY=0).
// Expected responses come from a word-array reference model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    typedef struct {
        bit          abort;
        logic [31:0] rd;
        bit          err;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [31:0] rd;
        bit          err;
    } exp0_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] addr, wd;
    logic [31:0] rd;
    logic        mem_stall, addr_err;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic [31:0] rd0;
    logic        stall0, err0;

    int errors = 0;
    int checks = 0;
    int stall_run = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref0 [DEPTH];
    exp_t  expq[$];
    exp0_t q0[$];

    int rd_exp = 0, wr_exp = 0, stall_exp = 0;
    int rd0_exp = 0, wr0_exp = 0;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count, wr_count, stall_count;
    logic [31:0] rd_count0, wr_count0, stall_count0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wd(wd),
        .rd(rd), .mem_stall(mem_stall), .addr_err(addr_err)
`ifdef DMEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count),
        .stall_count(stall_count)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .MemRead(r0), .MemWrite(w0),
        .addr(a0), .wd(d0),
        .rd(rd0), .mem_stall(stall0), .addr_err(err0)
`ifdef DMEM_STATS_EN
        , .rd_count(rd_count0), .wr_count(wr_count0),
        .stall_count(stall_count0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Main DUT monitor: classifies each cycle and pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_run = 0;
        end else if ((MemRead || MemWrite) && mem_stall) begin
            stall_run++;
        end else if (MemRead || MemWrite) begin
            if (expq.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("done_not_abort", 32'(e.abort), 32'd0);
                chk("rd", rd, e.rd);
                chk("addr_err", 32'(addr_err), 32'(e.err));
                chk("stall_cycles", 32'(stall_run), 32'(e.stalls));
            end
            stall_run = 0;
        end else if (mem_stall) begin
            if (expq.size() == 0) begin
                chk("unexpected_stall", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("abort_flag", 32'(e.abort), 32'd1);
                chk("abort_stalls", 32'(stall_run), 32'(e.stalls));
            end
            stall_run = 0;
        end else begin
            chk("idle_rd", rd, 32'd0);
            chk("idle_err", 32'(addr_err), 32'd0);
        end
    end

    always @(negedge clk) begin
        exp0_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("l0_rd", rd0, e.rd);
            chk("l0_err", 32'(err0), 32'(e.err));
            chk("l0_stall", 32'(stall0), 32'd0);
        end
    end

    task automatic access(input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int drop);
        exp_t e;
        bit   f, done;
        int   ix;
        f = (a[1:0] != 2'b00) || (r && w);
        ix = int'((a >> 2) % DEPTH);
        e.abort  = (drop >= 0);
        e.err    = f;
        e.stalls = e.abort ? drop : LAT;
        e.rd     = (!e.abort && r && !w && !f) ? ref_mem[ix] : 32'd0;
        if (!e.abort && !f) begin
            if (w) begin
                ref_mem[ix] = d;
                wr_exp++;
            end else if (r) begin
                rd_exp++;
            end
        end
        stall_exp += e.abort ? drop + 1 : LAT;
        expq.push_back(e);
        MemRead  = r;
        MemWrite = w;
        addr     = a;
        wd       = d;
        if (e.abort) begin
            repeat (drop) @(posedge clk);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            addr     = $urandom;
            wd       = $urandom;
            @(posedge clk);
            #1;
        end else begin
            if (LAT >= 2 && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                addr = $urandom;
                wd   = $urandom;
            end
            done = 1'b0;
            for (int k = 0; k < LAT + 4; k++) begin
                @(negedge clk);
                if (!mem_stall) begin
                    done = 1'b1;
                    break;
                end
            end
            chk("completion_timeout", 32'(done), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drive0(input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        exp0_t e;
        bit    f;
        int    ix;
        f  = (a[1:0] != 2'b00) || (r && w);
        ix = int'((a >> 2) % DEPTH);
        e.rd  = (r && !f) ? ref0[ix] : 32'd0;
        e.err = (r || w) && f;
        if (r && !f) rd0_exp++;
        if (w && !f) begin
            ref0[ix] = d;
            wr0_exp++;
        end
        q0.push_back(e);
        r0 = r;
        w0 = w;
        a0 = a;
        d0 = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 15) << 2) + ($urandom_range(0, 3) << 10);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        bit r, w;
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wd = '0;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref0[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(mem_stall), 32'd0);
        chk("reset_rd", rd, 32'd0);
        chk("reset_err", 32'(addr_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, -1);
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1);
        access(1'b1, 1'b0, 32'h10, 32'h0, -1);
        gap(1);
        access(1'b1, 1'b0, 32'h22, 32'h0, -1);
        access(1'b0, 1'b1, 32'h8, 32'hAAAA5555, LAT - 1);
        access(1'b1, 1'b0, 32'h8, 32'h0, -1);
        access(1'b1, 1'b1, 32'h4, 32'h0BAD0BAD, -1);
        access(1'b1, 1'b0, 32'h4, 32'h0, -1);
        access(1'b0, 1'b1, 32'h40C, 32'hCAFEF00D, -1);
        access(1'b1, 1'b0, 32'hC, 32'h0, -1);
        gap(2);

        // Reset lands while the write to word 0 is still waiting.
        MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h0; wd = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        MemWrite = 1'b0;
        rd_exp = 0; wr_exp = 0; stall_exp = 0;
        rd0_exp = 0; wr0_exp = 0;
        access(1'b1, 1'b0, 32'h0, 32'h0, -1);

        for (int n = 0; n < 150; n++) begin
            w = $urandom_range(0, 1);
            r = !w || ($urandom_range(0, 9) == 0);
            if (LAT >= 2 && $urandom_range(0, 9) == 0)
                access(r, w, rand_addr(), $urandom, $urandom_range(1, LAT - 1));
            else
                access(r, w, rand_addr(), $urandom, -1);
            gap($urandom_range(0, 2));
        end
        gap(2);

        for (int i = 0; i < 16; i++) drive0(1'b0, 1'b1, 32'(i * 4), $urandom);
        drive0(1'b0, 1'b1, 32'h4, 32'h12345678);
        drive0(1'b1, 1'b0, 32'h4, 32'h0);
        for (int n = 0; n < 200; n++) begin
            w = $urandom_range(0, 1);
            r = !w || ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) drive0(1'b0, 1'b0, rand_addr(), $urandom);
            else drive0(r, w, rand_addr(), $urandom);
        end
        r0 = 1'b0; w0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
`ifdef DMEM_STATS_EN
        chk("rd_count", rd_count, 32'(rd_exp));
        chk("wr_count", wr_count, 32'(wr_exp));
        chk("stall_count", stall_count, 32'(stall_exp));
        chk("l0_rd_count", rd_count0, 32'(rd0_exp));
        chk("l0_wr_count", wr_count0, 32'(wr0_exp));
        chk("l0_stall_count", stall_count0, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
